// File: rtl/byte_comp_if.sv
// byte_comp_if
//   Bundles the compare-stream and result signals of byte_comp_checker.
//   master : stimulus side.
//            Drives frame_start, comp_valid and comp_in, and observes the results.
//   slave  : the checker.
//            Consumes the stream and drives busy, frame_done, pass,
//            mismatch_bits, mismatch_bytes, first_bad_valid and first_bad_idx.
interface byte_comp_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 16,
    parameter int CNT_WIDTH  = 16
);
    logic                               frame_start;
    logic                               comp_valid;
    logic [DATA_WIDTH-1:0]              comp_in;
    logic                               busy;
    logic                               frame_done;
    logic                               pass;
    logic [CNT_WIDTH-1:0]               mismatch_bits;
    logic [$clog2(FRAME_LEN+1)-1:0]     mismatch_bytes;
    logic                               first_bad_valid;
    logic [$clog2(FRAME_LEN)-1:0]       first_bad_idx;

    modport master (
        output frame_start, comp_valid, comp_in,
        input  busy, frame_done, pass, mismatch_bits, mismatch_bytes,
               first_bad_valid, first_bad_idx
    );

    modport slave (
        input  frame_start, comp_valid, comp_in,
        output busy, frame_done, pass, mismatch_bits, mismatch_bytes,
               first_bad_valid, first_bad_idx
    );
endinterface

// File: rtl/byte_comp_checker.sv
// byte_comp_checker
//   Collects one frame of FRAME_LEN equivalence vectors (1 = bit matches).
//   For each frame it counts:
//     - mismatching bits, with a saturating counter;
//     - mismatching vectors.
//   It also records the index of the first bad vector.
//   It then reports a registered pass/fail verdict with a one-cycle frame_done pulse.
// Ports
//   clk   : rising-edge clock.
//   rst_n : asynchronous active-low reset.
//   bus   : byte_comp_if.slave.
//           Inputs:  frame_start, comp_valid, comp_in.
//           Outputs: busy, frame_done, pass, mismatch_bits, mismatch_bytes,
//                    first_bad_valid, first_bad_idx.
// The interface instance must use the same parameters as this module.
module byte_comp_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    byte_comp_if.slave   bus
);
    localparam int IDX_W   = $clog2(FRAME_LEN);
    localparam int BYTES_W = $clog2(FRAME_LEN + 1);
    localparam int ZW      = $clog2(DATA_WIDTH + 1);
    // One bit wider than the larger operand, so the raw sum cannot wrap before the saturation test.
    localparam int SUM_W   = ((CNT_WIDTH > ZW) ? CNT_WIDTH : ZW) + 1;
    localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W-CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_REPORT} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_WIDTH-1:0] bits_q, bits_d;
    logic [BYTES_W-1:0]   bytes_q, bytes_d;
    logic                 fbv_q, fbv_d;
    logic [IDX_W-1:0]     fbi_q, fbi_d;
    logic                 pass_q, pass_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic [ZW-1:0]        zeros;
    logic                 bad;
    logic [SUM_W-1:0]     sum;
    logic [CNT_WIDTH-1:0] bits_acc;
    logic [BYTES_W-1:0]   bytes_acc;

    // Per-vector mismatch statistics.
    // These are computed unconditionally and only used when a vector is accepted.
    always_comb begin
        zeros = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (!bus.comp_in[i]) zeros = zeros + ZW'(1);
        end
        bad       = (bus.comp_in != {DATA_WIDTH{1'b1}});
        sum       = SUM_W'(bits_q) + SUM_W'(zeros);
        bits_acc  = (sum > SAT_MAX) ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
        bytes_acc = bytes_q + BYTES_W'(bad);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bits_d  = bits_q;
        bytes_d = bytes_q;
        fbv_d   = fbv_q;
        fbi_d   = fbi_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (bus.frame_start) begin
                    // A new frame, or a restart mid-frame, discards everything seen so far.
                    state_d = S_RUN;
                    idx_d   = '0;
                    bits_d  = '0;
                    bytes_d = '0;
                    fbv_d   = 1'b0;
                    fbi_d   = '0;
                    pass_d  = 1'b0;
                end else if (state_q == S_RUN && bus.comp_valid) begin
                    bits_d  = bits_acc;
                    bytes_d = bytes_acc;
                    idx_d   = idx_q + IDX_W'(1);
                    if (bad && !fbv_q) begin
                        fbv_d = 1'b1;
                        fbi_d = idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        // pass is taken from the final counts, so it is valid together with frame_done.
                        state_d = S_REPORT;
                        idx_d   = '0;
                        done_d  = 1'b1;
                        pass_d  = (bits_acc == '0) && (bytes_acc == '0);
                    end
                end
            end
            S_REPORT: state_d = S_IDLE;   // frame_start is deliberately ignored here
            default:  state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            bits_q  <= '0;
            bytes_q <= '0;
            fbv_q   <= 1'b0;
            fbi_q   <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bits_q  <= bits_d;
            bytes_q <= bytes_d;
            fbv_q   <= fbv_d;
            fbi_q   <= fbi_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.frame_done      = done_q;
    assign bus.pass            = pass_q;
    assign bus.mismatch_bits   = bits_q;
    assign bus.mismatch_bytes  = bytes_q;
    assign bus.first_bad_valid = fbv_q;
    assign bus.first_bad_idx   = fbi_q;
endmodule

// File: tb/tb_byte_comp_checker.sv
module tb_byte_comp_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    byte_comp_if #(.DATA_WIDTH(8), .FRAME_LEN(16), .CNT_WIDTH(16)) a ();
    byte_comp_if #(.DATA_WIDTH(8), .FRAME_LEN(16), .CNT_WIDTH(4))  b ();

    byte_comp_checker #(.DATA_WIDTH(8), .FRAME_LEN(16), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a.slave));
    byte_comp_checker #(.DATA_WIDTH(8), .FRAME_LEN(16), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b.slave));

    // Advance one rising edge; outputs are then sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a();
        a.frame_start = 1'b1;
        step();
        a.frame_start = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] v);
        a.comp_valid = 1'b1;
        a.comp_in    = v;
        step();
        a.comp_valid = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++; if (a.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", a.busy); end
        n_cmp++; if (a.frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", a.frame_done); end
        n_cmp++; if (a.pass !== 1'b0) begin n_bad++; $display("FAIL rst_pass got %b want 0", a.pass); end
        n_cmp++; if (a.mismatch_bits !== 16'd0) begin n_bad++; $display("FAIL rst_bits got %0d want 0", a.mismatch_bits); end
        n_cmp++; if (a.mismatch_bytes !== 5'd0) begin n_bad++; $display("FAIL rst_bytes got %0d want 0", a.mismatch_bytes); end
        n_cmp++; if (a.first_bad_valid !== 1'b0 || a.first_bad_idx !== 4'd0) begin n_bad++;
            $display("FAIL rst_first got v=%b i=%0d want v=0 i=0", a.first_bad_valid, a.first_bad_idx); end
        rst_n = 1'b1;
        step();
        $display("reset: checked");
    endtask

    task automatic test_all_match();
        start_a();
        n_cmp++; if (a.busy !== 1'b1) begin n_bad++; $display("FAIL t1_busy got %b want 1", a.busy); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (a.frame_done !== 1'b0) begin n_bad++; $display("FAIL t1_early_done at %0d got 1 want 0", i); end
            send_a(8'hFF);
        end
        n_cmp++; if (a.frame_done !== 1'b1) begin n_bad++; $display("FAIL t1_done got %b want 1", a.frame_done); end
        n_cmp++; if (a.pass !== 1'b1) begin n_bad++; $display("FAIL t1_pass got %b want 1", a.pass); end
        n_cmp++; if (a.mismatch_bits !== 16'd0 || a.mismatch_bytes !== 5'd0) begin n_bad++;
            $display("FAIL t1_counts got bits=%0d bytes=%0d want 0/0", a.mismatch_bits, a.mismatch_bytes); end
        n_cmp++; if (a.first_bad_valid !== 1'b0) begin n_bad++; $display("FAIL t1_fbv got %b want 0", a.first_bad_valid); end
        n_cmp++; if (a.busy !== 1'b0) begin n_bad++; $display("FAIL t1_busy_report got %b want 0", a.busy); end
        step();
        n_cmp++; if (a.frame_done !== 1'b0) begin n_bad++; $display("FAIL t1_done_pulse got %b want 0", a.frame_done); end
        n_cmp++; if (a.pass !== 1'b1) begin n_bad++; $display("FAIL t1_pass_hold got %b want 1", a.pass); end
        $display("t1 all-match frame: bits=%0d bytes=%0d pass=%b", a.mismatch_bits, a.mismatch_bytes, a.pass);
    endtask

    task automatic test_mixed();
        logic [7:0] v;
        start_a();
        for (int i = 0; i < 16; i++) begin
            v = 8'hFF;
            if (i == 3) v = 8'hFE;
            if (i == 9) v = 8'h00;
            send_a(v);
        end
        n_cmp++; if (a.frame_done !== 1'b1) begin n_bad++; $display("FAIL t2_done got %b want 1", a.frame_done); end
        n_cmp++; if (a.mismatch_bits !== 16'd9) begin n_bad++; $display("FAIL t2_bits got %0d want 9", a.mismatch_bits); end
        n_cmp++; if (a.mismatch_bytes !== 5'd2) begin n_bad++; $display("FAIL t2_bytes got %0d want 2", a.mismatch_bytes); end
        n_cmp++; if (a.first_bad_valid !== 1'b1 || a.first_bad_idx !== 4'd3) begin n_bad++;
            $display("FAIL t2_first got v=%b i=%0d want v=1 i=3", a.first_bad_valid, a.first_bad_idx); end
        n_cmp++; if (a.pass !== 1'b0) begin n_bad++; $display("FAIL t2_pass got %b want 0", a.pass); end
        step();
        $display("t2 mixed frame: bits=%0d bytes=%0d idx=%0d", a.mismatch_bits, a.mismatch_bytes, a.first_bad_idx);
    endtask

    task automatic test_gaps();
        start_a();
        for (int i = 0; i < 16; i++) begin
            send_a(8'h00);
            if (i < 15) begin
                n_cmp++; if (a.frame_done !== 1'b0) begin n_bad++; $display("FAIL t3_early_done at %0d got 1 want 0", i); end
                a.comp_in = 8'h00;
                step();   // gap cycle with comp_valid low
                n_cmp++; if (a.mismatch_bits !== 16'((i + 1) * 8)) begin n_bad++;
                    $display("FAIL t3_gap_hold at %0d got %0d want %0d", i, a.mismatch_bits, (i + 1) * 8); end
            end
        end
        n_cmp++; if (a.frame_done !== 1'b1) begin n_bad++; $display("FAIL t3_done got %b want 1", a.frame_done); end
        n_cmp++; if (a.mismatch_bits !== 16'd128 || a.mismatch_bytes !== 5'd16) begin n_bad++;
            $display("FAIL t3_counts got bits=%0d bytes=%0d want 128/16", a.mismatch_bits, a.mismatch_bytes); end
        n_cmp++; if (a.first_bad_valid !== 1'b1 || a.first_bad_idx !== 4'd0) begin n_bad++;
            $display("FAIL t3_first got v=%b i=%0d want v=1 i=0", a.first_bad_valid, a.first_bad_idx); end
        step();
        $display("t3 gapped frame: bits=%0d bytes=%0d", a.mismatch_bits, a.mismatch_bytes);
    endtask

    task automatic test_restart();
        start_a();
        for (int i = 0; i < 5; i++) send_a((i == 2) ? 8'h0F : 8'hFF);
        n_cmp++; if (a.mismatch_bits !== 16'd4) begin n_bad++; $display("FAIL t4_pre_bits got %0d want 4", a.mismatch_bits); end
        // Restart with a simultaneous valid vector, which must not be counted.
        a.comp_valid = 1'b1;
        a.comp_in    = 8'h00;
        start_a();
        a.comp_valid = 1'b0;
        n_cmp++; if (a.frame_done !== 1'b0 || a.busy !== 1'b1) begin n_bad++;
            $display("FAIL t4_restart got done=%b busy=%b want 0/1", a.frame_done, a.busy); end
        n_cmp++; if (a.mismatch_bits !== 16'd0 || a.mismatch_bytes !== 5'd0 || a.first_bad_valid !== 1'b0) begin n_bad++;
            $display("FAIL t4_clear got bits=%0d bytes=%0d fbv=%b want 0/0/0", a.mismatch_bits, a.mismatch_bytes, a.first_bad_valid); end
        for (int i = 0; i < 16; i++) send_a(8'hFF);
        n_cmp++; if (a.frame_done !== 1'b1 || a.pass !== 1'b1 || a.mismatch_bits !== 16'd0) begin n_bad++;
            $display("FAIL t4_final got done=%b pass=%b bits=%0d want 1/1/0", a.frame_done, a.pass, a.mismatch_bits); end
        // frame_start during the report cycle is ignored: the FSM still goes idle.
        start_a();
        n_cmp++; if (a.busy !== 1'b0 || a.pass !== 1'b1) begin n_bad++;
            $display("FAIL t4_report_start got busy=%b pass=%b want 0/1", a.busy, a.pass); end
        // A vector offered while idle is ignored.
        send_a(8'h00);
        n_cmp++; if (a.mismatch_bits !== 16'd0 || a.busy !== 1'b0) begin n_bad++;
            $display("FAIL t4_idle_valid got bits=%0d busy=%b want 0/0", a.mismatch_bits, a.busy); end
        $display("t4 restart: pass=%b bits=%0d", a.pass, a.mismatch_bits);
    endtask

    task automatic test_async_reset();
        start_a();
        for (int i = 0; i < 7; i++) send_a(8'h00);
        n_cmp++; if (a.mismatch_bits !== 16'd56) begin n_bad++; $display("FAIL t5_pre_bits got %0d want 56", a.mismatch_bits); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (a.busy !== 1'b0 || a.mismatch_bits !== 16'd0 || a.mismatch_bytes !== 5'd0 || a.first_bad_valid !== 1'b0) begin n_bad++;
            $display("FAIL t5_async got busy=%b bits=%0d bytes=%0d fbv=%b want all 0", a.busy, a.mismatch_bits, a.mismatch_bytes, a.first_bad_valid); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) send_a(8'h00);
        n_cmp++; if (a.busy !== 1'b0 || a.mismatch_bits !== 16'd0 || a.frame_done !== 1'b0) begin n_bad++;
            $display("FAIL t5_post got busy=%b bits=%0d done=%b want 0/0/0", a.busy, a.mismatch_bits, a.frame_done); end
        $display("t5 async reset: busy=%b bits=%0d", a.busy, a.mismatch_bits);
    endtask

    task automatic test_saturate();
        b.frame_start = 1'b1;
        step();
        b.frame_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b.comp_valid = 1'b1;
            b.comp_in    = 8'h00;
            step();
            if (i == 0) begin
                n_cmp++; if (b.mismatch_bits !== 4'd8) begin n_bad++; $display("FAIL t6_first got %0d want 8", b.mismatch_bits); end
            end
            if (i == 2) begin
                n_cmp++; if (b.mismatch_bits !== 4'd15) begin n_bad++; $display("FAIL t6_sat_early got %0d want 15", b.mismatch_bits); end
            end
        end
        b.comp_valid = 1'b0;
        n_cmp++; if (b.frame_done !== 1'b1) begin n_bad++; $display("FAIL t6_done got %b want 1", b.frame_done); end
        n_cmp++; if (b.mismatch_bits !== 4'd15 || b.mismatch_bytes !== 5'd16) begin n_bad++;
            $display("FAIL t6_counts got bits=%0d bytes=%0d want 15/16", b.mismatch_bits, b.mismatch_bytes); end
        n_cmp++; if (b.pass !== 1'b0) begin n_bad++; $display("FAIL t6_pass got %b want 0", b.pass); end
        step();
        $display("t6 saturation: bits=%0d bytes=%0d", b.mismatch_bits, b.mismatch_bytes);
    endtask

    initial begin
        a.frame_start = 1'b0; a.comp_valid = 1'b0; a.comp_in = 8'h00;
        b.frame_start = 1'b0; b.comp_valid = 1'b0; b.comp_in = 8'h00;
        test_reset();
        test_all_match();
        test_mixed();
        test_gaps();
        test_restart();
        test_async_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
